// File: rtl/bcd_seg_scan_if.sv
// Bus between a BCD producer and the 3-digit segment scanner.
// The master drives bcd/load and reads the display pins and status; the slave is the scanner.
interface bcd_seg_scan_if;
  logic [15:0] bcd;
  logic        load;
  logic [6:0]  seg;
  logic [2:0]  an;
  logic        pending;
  logic        frame_done;

  modport master (output bcd, load, input seg, an, pending, frame_done);
  modport slave  (input bcd, load, output seg, an, pending, frame_done);
endinterface

// File: rtl/bcd_seg_scan.sv
// 3-digit multiplexed 7-segment driver with tear-free commit of loaded BCD values at frame wrap.
// Optional LEADING_ZERO_BLANK_EN: blanks leading-zero hundreds/tens digits.
//
// slot       | meaning
// SLOT_ONES  | next tick drives the ones digit
// SLOT_TENS  | next tick drives the tens digit
// SLOT_HUNDS | next tick drives the hundreds digit; that tick wraps the frame and may commit
module bcd_seg_scan #(
  parameter int CLK_DIV        = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input logic            clk,
  input logic            reset,
  bcd_seg_scan_if.slave  bus_if
);

  localparam int             PW        = $clog2(CLK_DIV);
  localparam logic [PW-1:0]  PRESC_MAX = PW'(CLK_DIV - 1);
  localparam logic [6:0]     SEG_OFF   = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [2:0]     AN_OFF    = AN_ACTIVE_LOW ? 3'b111 : 3'b000;

  typedef enum logic [1:0] {
    SLOT_ONES  = 2'd0,
    SLOT_TENS  = 2'd1,
    SLOT_HUNDS = 2'd2
  } slot_e;

  logic [PW-1:0] presc_q, presc_d;
  slot_e         slot_q, slot_d;
  logic [9:0]    shown_q, shown_d;
  logic [9:0]    pend_val_q, pend_val_d;
  logic          pending_q, pending_d;
  logic          frame_done_q, frame_done_d;
  logic [6:0]    seg_q, seg_d;
  logic [2:0]    an_q, an_d;

  logic          tick;
  logic          wrap;
  logic          blank;
  logic          lz_hund;
  logic          lz_tens;
  logic [3:0]    digit;
  logic [2:0]    an_sel;
  logic [6:0]    pat;
  logic [5:0]    unused_bcd_hi;

  assign unused_bcd_hi = bus_if.bcd[15:10];

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'h3F;
      4'd1:    seg_decode = 7'h06;
      4'd2:    seg_decode = 7'h5B;
      4'd3:    seg_decode = 7'h4F;
      4'd4:    seg_decode = 7'h66;
      4'd5:    seg_decode = 7'h6D;
      4'd6:    seg_decode = 7'h7D;
      4'd7:    seg_decode = 7'h07;
      4'd8:    seg_decode = 7'h7F;
      4'd9:    seg_decode = 7'h6F;
      default: seg_decode = 7'h40;
    endcase
  endfunction

  always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
    lz_hund = (shown_q[9:8] == 2'd0);
    lz_tens = lz_hund && (shown_q[7:4] == 4'd0);
`else
    lz_hund = 1'b0;
    lz_tens = 1'b0;
`endif
  end

  always_comb begin
    tick         = (presc_q == PRESC_MAX);
    presc_d      = tick ? '0 : presc_q + 1'b1;
    slot_d       = slot_q;
    shown_d      = shown_q;
    pend_val_d   = pend_val_q;
    pending_d    = pending_q;
    seg_d        = seg_q;
    an_d         = an_q;
    digit        = 4'd0;
    an_sel       = 3'b000;
    blank        = 1'b1;

    case (slot_q)
      SLOT_ONES: begin
        digit  = shown_q[3:0];
        an_sel = 3'b001;
        blank  = 1'b0;
      end
      SLOT_TENS: begin
        digit  = shown_q[7:4];
        an_sel = 3'b010;
        blank  = lz_tens;
      end
      SLOT_HUNDS: begin
        digit  = {2'b00, shown_q[9:8]};
        an_sel = 3'b100;
        blank  = lz_hund;
      end
      default: begin
        digit  = 4'd0;
        an_sel = 3'b000;
        blank  = 1'b1;
      end
    endcase
    pat = seg_decode(digit);

    wrap         = tick && (slot_q == SLOT_HUNDS);
    frame_done_d = wrap;

    if (tick) begin
      if (blank) begin
        seg_d = SEG_OFF;
        an_d  = AN_OFF;
      end else begin
        seg_d = SEG_ACTIVE_LOW ? ~pat : pat;
        an_d  = AN_ACTIVE_LOW ? ~an_sel : an_sel;
      end
      case (slot_q)
        SLOT_ONES: slot_d = SLOT_TENS;
        SLOT_TENS: slot_d = SLOT_HUNDS;
        default:   slot_d = SLOT_ONES;
      endcase
    end

    // Commit uses the old pending value; a same-edge load re-arms pending with the new one.
    if (wrap && pending_q) begin
      shown_d   = pend_val_q;
      pending_d = 1'b0;
    end
    if (bus_if.load) begin
      pend_val_d = bus_if.bcd[9:0];
      pending_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q      <= '0;
      slot_q       <= SLOT_ONES;
      shown_q      <= '0;
      pend_val_q   <= '0;
      pending_q    <= 1'b0;
      frame_done_q <= 1'b0;
      seg_q        <= SEG_OFF;
      an_q         <= AN_OFF;
    end else begin
      presc_q      <= presc_d;
      slot_q       <= slot_d;
      shown_q      <= shown_d;
      pend_val_q   <= pend_val_d;
      pending_q    <= pending_d;
      frame_done_q <= frame_done_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
    end
  end

  assign bus_if.seg        = seg_q;
  assign bus_if.an         = an_q;
  assign bus_if.pending    = pending_q;
  assign bus_if.frame_done = frame_done_q;

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Directed bench for bcd_seg_scan with CLK_DIV=4, active-low segments and anodes.
// Expected values are hand-decoded; LEADING_ZERO_BLANK_EN switches the blanked-digit expectations.
module tb_bcd_seg_scan;

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  bcd_seg_scan_if bus_if ();

  bcd_seg_scan #(
    .CLK_DIV       (4),
    .SEG_ACTIVE_LOW(1'b1),
    .AN_ACTIVE_LOW (1'b1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus_if(bus_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_disp(input string tag, input logic [2:0] exp_an, input logic [6:0] exp_seg);
    chk({tag, "_an"}, {13'd0, bus_if.an}, {13'd0, exp_an});
    chk({tag, "_seg"}, {9'd0, bus_if.seg}, {9'd0, exp_seg});
  endtask

  // Edge numbers E<n> count rising edges since reset release; ticks land on E4, E8, ...
  initial begin
    checks         = 0;
    errors         = 0;
    reset          = 1'b1;
    bus_if.load    = 1'b0;
    bus_if.bcd     = 16'h0000;
    cyc(3);
    reset = 1'b0;
    chk_disp("reset", 3'b111, 7'h7F);
    chk("reset_pending", {15'd0, bus_if.pending}, 16'd0);
    chk("reset_fd", {15'd0, bus_if.frame_done}, 16'd0);

    cyc(3);                                      // E3
    chk_disp("pre_tick", 3'b111, 7'h7F);
    cyc(1);                                      // E4
    chk_disp("first_ones", 3'b110, 7'h40);

    bus_if.bcd  = 16'h0255;
    bus_if.load = 1'b1;
    cyc(1);                                      // E5
    bus_if.load = 1'b0;
    chk("pend_after_load", {15'd0, bus_if.pending}, 16'd1);
    chk_disp("hold_ones", 3'b110, 7'h40);
    cyc(3);                                      // E8
    chk_disp("tens0", LZB ? 3'b111 : 3'b101, LZB ? 7'h7F : 7'h40);
    chk("pend_hold", {15'd0, bus_if.pending}, 16'd1);
    cyc(3);                                      // E11
    chk("fd_before_wrap", {15'd0, bus_if.frame_done}, 16'd0);
    cyc(1);                                      // E12
    chk_disp("hund0", LZB ? 3'b111 : 3'b011, LZB ? 7'h7F : 7'h40);
    chk("fd_wrap1", {15'd0, bus_if.frame_done}, 16'd1);
    chk("pend_commit1", {15'd0, bus_if.pending}, 16'd0);
    cyc(1);                                      // E13
    chk("fd_pulse_end", {15'd0, bus_if.frame_done}, 16'd0);

    cyc(3);                                      // E16
    chk_disp("255_ones", 3'b110, 7'h12);
    cyc(4);                                      // E20
    chk_disp("255_tens", 3'b101, 7'h12);
    cyc(4);                                      // E24
    chk_disp("255_hund", 3'b011, 7'h24);
    chk("fd_wrap2", {15'd0, bus_if.frame_done}, 16'd1);

    cyc(1);                                      // E25
    bus_if.bcd  = 16'h0123;
    bus_if.load = 1'b1;
    cyc(1);                                      // E26
    bus_if.bcd  = 16'h0045;
    cyc(1);                                      // E27
    bus_if.load = 1'b0;
    chk("pend_two_loads", {15'd0, bus_if.pending}, 16'd1);
    cyc(9);                                      // E36
    chk("fd_wrap3", {15'd0, bus_if.frame_done}, 16'd1);
    chk("pend_commit3", {15'd0, bus_if.pending}, 16'd0);
    cyc(4);                                      // E40
    chk_disp("045_ones", 3'b110, 7'h12);
    bus_if.bcd  = 16'h0380;
    bus_if.load = 1'b1;
    cyc(1);                                      // E41
    bus_if.load = 1'b0;
    cyc(3);                                      // E44
    chk_disp("045_tens", 3'b101, 7'h19);

    cyc(3);                                      // E47
    bus_if.bcd  = 16'h00A7;
    bus_if.load = 1'b1;
    cyc(1);                                      // E48: wrap with coincident load
    bus_if.load = 1'b0;
    chk_disp("045_hund", LZB ? 3'b111 : 3'b011, LZB ? 7'h7F : 7'h40);
    chk("fd_wrap4", {15'd0, bus_if.frame_done}, 16'd1);
    chk("pend_coincident", {15'd0, bus_if.pending}, 16'd1);
    cyc(4);                                      // E52
    chk_disp("380_ones", 3'b110, 7'h40);
    cyc(4);                                      // E56
    chk_disp("380_tens", 3'b101, 7'h00);
    cyc(4);                                      // E60
    chk_disp("380_hund", 3'b011, 7'h30);
    chk("fd_wrap5", {15'd0, bus_if.frame_done}, 16'd1);
    chk("pend_commit5", {15'd0, bus_if.pending}, 16'd0);
    cyc(4);                                      // E64
    chk_disp("0A7_ones", 3'b110, 7'h78);
    cyc(4);                                      // E68
    chk_disp("0A7_dash", 3'b101, 7'h3F);
    cyc(4);                                      // E72
    chk_disp("0A7_hund", LZB ? 3'b111 : 3'b011, LZB ? 7'h7F : 7'h40);

    bus_if.bcd  = 16'hFC07;
    bus_if.load = 1'b1;
    cyc(1);                                      // E73
    bus_if.load = 1'b0;
    cyc(11);                                     // E84
    chk("fd_wrap7", {15'd0, bus_if.frame_done}, 16'd1);
    cyc(4);                                      // E88
    chk_disp("007_ones", 3'b110, 7'h78);
    cyc(4);                                      // E92
    chk_disp("007_tens", LZB ? 3'b111 : 3'b101, LZB ? 7'h7F : 7'h40);
    cyc(4);                                      // E96
    chk_disp("007_hund", LZB ? 3'b111 : 3'b011, LZB ? 7'h7F : 7'h40);

    cyc(1);                                      // E97
    bus_if.bcd  = 16'h0299;
    bus_if.load = 1'b1;
    cyc(1);                                      // E98
    chk("pend_before_rst", {15'd0, bus_if.pending}, 16'd1);
    reset       = 1'b1;
    bus_if.bcd  = 16'h0111;
    cyc(1);                                      // reset edge, load held high
    reset       = 1'b0;
    bus_if.load = 1'b0;
    chk_disp("midrst", 3'b111, 7'h7F);
    chk("midrst_pending", {15'd0, bus_if.pending}, 16'd0);
    chk("midrst_fd", {15'd0, bus_if.frame_done}, 16'd0);
    cyc(4);
    chk_disp("post_rst_ones", 3'b110, 7'h40);
    chk("post_rst_pending", {15'd0, bus_if.pending}, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
